trap_monitor: RTL and testbench
===============================

// Module: trap_monitor
// PURPOSE
//  Parametrised successor of the top-level run/halt monitor. Watches the exception vector emitted by the CPU
//  and gates PC write-enable through a Moore FSM. Latches trap cause and EPC, and supports resume and single-step.
//  Sits between CPU (exceptions, commit PC) and PC (write enable).
// PARAMETERS
//  EXC_WIDTH  8           width of exception vector
//  PC_WIDTH   64          width of commit PC / EPC
//  ERR_MASK   8'b0000_0111 exception bits treated as fatal (-> ERROR)
//  HALT_MASK  8'b0001_1000 exception bits treated as halting (ECALL/EBREAK -> HALT)
//  CNT_WIDTH  32          width of trap counter(s)
// PORTS
//  clk_i          in   1                  clock
//  rst_i          in   1                  async reset, active-low
//  exc_i          in   EXC_WIDTH          exception flags from CPU, sampled each posedge
//  commit_pc_i    in   PC_WIDTH           PC of instruction committing this cycle
//  resume_i       in   1                  HALT -> NORMAL request (level, sampled)
//  step_i         in   1                  HALT -> STEP request (level, sampled)
//  pc_we_o        out  1                  PC write enable (Moore)
//  state_o        out  3                  current monitor_state_e
//  cause_valid_o  out  1                  cause_o/epc_o hold a latched trap
//  cause_o        out  $clog2(EXC_WIDTH)  index of latched trap bit
//  epc_o          out  PC_WIDTH           commit_pc_i captured at trap
//  trap_cnt_o     out  CNT_WIDTH          saturating count of HALT+ERROR entries
//  stat_sel_i     in   $clog2(EXC_WIDTH)  [TRAP_STATS_EN] counter select
//  stat_cnt_o     out  CNT_WIDTH          [TRAP_STATS_EN] selected per-cause count
// BEHAVIOUR
//  Reset (rst_i=0, async): state=RST, pc_we_o=0, cause_valid_o=0, cause_o=0, epc_o=0, trap_cnt_o=0.
//  States: RST, NORMAL, HALT, STEP, ERROR. pc_we_o = (state==NORMAL || state==STEP).
//  RST   -> NORMAL on first clock after reset release (one RST cycle, pc_we_o=0).
//  NORMAL/STEP: err = exc_i & ERR_MASK, hlt = exc_i & HALT_MASK.
//   - err!=0 -> ERROR; cause_o = lowest set index of err.
//   - else hlt!=0 -> HALT; cause_o = lowest set index of hlt.
//   - else NORMAL stays NORMAL; STEP -> HALT (exactly one pc_we_o cycle).
//   - On any trap entry: cause_valid_o<=1, epc_o<=commit_pc_i, trap_cnt_o+=1 (saturate at all-ones).
//  HALT: exc_i bits other than err are ignored.
//   - err!=0 -> ERROR (latches as above).
//   - else resume_i -> NORMAL; else step_i -> STEP.
//   - resume_i and step_i both high: resume wins.
//  ERROR: sticky until reset; resume_i/step_i/exc_i ignored; pc_we_o=0.
//  Latency: exc_i high at edge N -> state_o/pc_we_o change visible after edge N (one cycle).
//  cause_o/epc_o hold their value until the next trap entry. resume does not clear cause_valid_o.
//  Bits in neither mask are ignored. A bit in both masks is treated as error.
//  Reset asserted mid-STEP/HALT: immediate return to RST; all latched state cleared.
// CONFIGURATION
//  TRAP_STATS_EN defined: EXC_WIDTH saturating per-cause counters, each incremented on trap entry with that
//   cause. stat_cnt_o = counter[stat_sel_i], combinational. stat_sel_i >= EXC_WIDTH -> 0. Counters reset to 0.
//  TRAP_STATS_EN undefined: stat_sel_i/stat_cnt_o absent, no counter storage.
// STRUCTURE
//  monitor_pkg: typedef enum logic[2:0] monitor_state_e {MS_RST=0, MS_NORMAL=1, MS_HALT=2, MS_STEP=3, MS_ERROR=4};
//   also default ERR_MASK/HALT_MASK constants and exception bit indices (EXC_ECALL=3, EXC_EBREAK=4).
//  Sub-module lowbit_enc #(W): lowest-set-bit index + any flag; instanced twice (err, hlt).
// TESTING
//  1 Release reset, exc_i=0 -> state RST for 1 cycle, then NORMAL, pc_we_o=1, trap_cnt_o=0.
//  2 NORMAL, exc_i=8'h10, commit_pc_i=64'h8000_0010 -> HALT, cause_o=4, epc_o=64'h8000_0010, pc_we_o=0, cnt=1.
//  3 HALT, step_i=1 for 1 cycle -> exactly one pc_we_o cycle (STEP), then HALT; step+resume together -> NORMAL.
//  4 NORMAL, exc_i=8'h1A -> ERROR, cause_o=1. Then resume_i=1 -> remains ERROR until rst_i=0.
//  5 HALT, exc_i=8'h04 with resume_i=1 -> ERROR, cause_o=2. Reset mid-HALT -> RST, cause_valid_o=0.
//  6 TRAP_STATS_EN: 3x EBREAK, 1x ECALL -> stat_sel_i=4 gives 3, =3 gives 1; force cnt to max-1, 2 traps -> saturates.

Source files
------------

// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : monitor_pkg
//  Purpose : Shared types and constants for the trap monitor. This covers the
//            monitor state encoding, the default fatal and halting exception
//            masks, and the exception bit indices.
//  Revision: 1.0 - initial release
// ============================================================================
package monitor_pkg;

    typedef enum logic [2:0] {
        MS_RST    = 3'd0,
        MS_NORMAL = 3'd1,
        MS_HALT   = 3'd2,
        MS_STEP   = 3'd3,
        MS_ERROR  = 3'd4
    } monitor_state_e;

    // Exception bit positions in the CPU exception vector
    localparam int EXC_ECALL  = 3;
    localparam int EXC_EBREAK = 4;

    // Default classification of the 8-bit exception vector
    localparam logic [7:0] c_ERR_MASK_DFLT  = 8'b0000_0111;
    localparam logic [7:0] c_HALT_MASK_DFLT = 8'b0001_1000;

endpackage : monitor_pkg
`default_nettype wire

// File: rtl/trap_monitor_lowbit_enc.sv
`default_nettype none
// ============================================================================
//  Module  : lowbit_enc
//  Purpose : Finds the index of the lowest set bit of a vector and raises a
//            flag when any bit is set. The index is 0 when no bit is set.
//  Revision: 1.0 - initial release
// ============================================================================
module lowbit_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0]                       vec_i,
    output logic [((W > 1) ? $clog2(W) : 1)-1:0] idx_o,
    output logic                               any_o
);

    localparam int c_IDX_W = (W > 1) ? $clog2(W) : 1;

    // Scan from the top down so the lowest set bit is the last one assigned
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = c_IDX_W'(i);
            end
        end
    end

    assign any_o = |vec_i;

endmodule : lowbit_enc
`default_nettype wire

// File: rtl/trap_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : trap_monitor
//  Purpose : Run/halt monitor that sits between the CPU and the PC. It watches
//            the exception vector and gates PC write-enable through a Moore
//            FSM (RST/NORMAL/HALT/STEP/ERROR). It also latches the trap cause
//            and EPC, and counts trap entries with a saturating counter.
//  Config  : TRAP_STATS_EN - adds saturating per-cause counters, readable
//            through stat_sel_i/stat_cnt_o.
//  Revision: 1.0 - initial release
// ============================================================================
module trap_monitor
    import monitor_pkg::*;
#(
    parameter int                 EXC_WIDTH = 8,
    parameter int                 PC_WIDTH  = 64,
    parameter logic [EXC_WIDTH-1:0] ERR_MASK  = EXC_WIDTH'(c_ERR_MASK_DFLT),
    parameter logic [EXC_WIDTH-1:0] HALT_MASK = EXC_WIDTH'(c_HALT_MASK_DFLT),
    parameter int                 CNT_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [EXC_WIDTH-1:0]         exc_i,
    input  logic [PC_WIDTH-1:0]          commit_pc_i,
    input  logic                         resume_i,
    input  logic                         step_i,
    output logic                         pc_we_o,
    output logic [2:0]                   state_o,
    output logic                         cause_valid_o,
    output logic [$clog2(EXC_WIDTH)-1:0] cause_o,
    output logic [PC_WIDTH-1:0]          epc_o,
    output logic [CNT_WIDTH-1:0]         trap_cnt_o
`ifdef TRAP_STATS_EN
    ,
    input  logic [$clog2(EXC_WIDTH)-1:0] stat_sel_i,
    output logic [CNT_WIDTH-1:0]         stat_cnt_o
`endif
);

    localparam int c_CAUSE_W = $clog2(EXC_WIDTH);

    monitor_state_e         r_state;
    monitor_state_e         w_state_nxt;
    logic [EXC_WIDTH-1:0]   w_err;
    logic [EXC_WIDTH-1:0]   w_hlt;
    logic [c_CAUSE_W-1:0]   w_err_idx;
    logic [c_CAUSE_W-1:0]   w_hlt_idx;
    logic                   w_err_any;
    logic                   w_hlt_any;
    logic                   w_trap_entry;
    logic [c_CAUSE_W-1:0]   w_trap_cause;

    // A bit present in both masks is reported as an error, because the error
    // branch is evaluated first.
    assign w_err = exc_i & ERR_MASK;
    assign w_hlt = exc_i & HALT_MASK;

    lowbit_enc #(.W(EXC_WIDTH)) u_err_enc (
        .vec_i (w_err),
        .idx_o (w_err_idx),
        .any_o (w_err_any)
    );

    lowbit_enc #(.W(EXC_WIDTH)) u_hlt_enc (
        .vec_i (w_hlt),
        .idx_o (w_hlt_idx),
        .any_o (w_hlt_any)
    );

    // State register; reset drops straight back to RST from any state
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= MS_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, trap-entry detection and Moore PC write-enable
    always_comb begin
        w_state_nxt  = r_state;
        w_trap_entry = 1'b0;
        w_trap_cause = '0;
        pc_we_o      = 1'b0;
        case (r_state)
            MS_RST: begin
                w_state_nxt = MS_NORMAL;
            end
            MS_NORMAL, MS_STEP: begin
                pc_we_o = 1'b1;
                if (w_err_any) begin
                    w_state_nxt  = MS_ERROR;
                    w_trap_entry = 1'b1;
                    w_trap_cause = w_err_idx;
                end else if (w_hlt_any) begin
                    w_state_nxt  = MS_HALT;
                    w_trap_entry = 1'b1;
                    w_trap_cause = w_hlt_idx;
                end else if (r_state == MS_STEP) begin
                    w_state_nxt = MS_HALT;
                end
            end
            MS_HALT: begin
                if (w_err_any) begin
                    w_state_nxt  = MS_ERROR;
                    w_trap_entry = 1'b1;
                    w_trap_cause = w_err_idx;
                end else if (resume_i) begin
                    w_state_nxt = MS_NORMAL;
                end else if (step_i) begin
                    w_state_nxt = MS_STEP;
                end
            end
            MS_ERROR: begin
                w_state_nxt = MS_ERROR;
            end
            default: begin
                w_state_nxt = MS_RST;
            end
        endcase
    end

    assign state_o = r_state;

    // Latch cause/EPC on every trap entry and bump the saturating trap count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cause_valid_o <= 1'b0;
            cause_o       <= '0;
            epc_o         <= '0;
            trap_cnt_o    <= '0;
        end else if (w_trap_entry) begin
            cause_valid_o <= 1'b1;
            cause_o       <= w_trap_cause;
            epc_o         <= commit_pc_i;
            if (trap_cnt_o != {CNT_WIDTH{1'b1}}) begin
                trap_cnt_o <= trap_cnt_o + 1'b1;
            end
        end
    end

`ifdef TRAP_STATS_EN
    logic [CNT_WIDTH-1:0] r_stat_cnt [EXC_WIDTH];

    generate
        for (genvar g = 0; g < EXC_WIDTH; g++) begin : g_stat_cnt
            // Saturating count of trap entries whose cause is this bit
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_stat_cnt[g] <= '0;
                end else if (w_trap_entry && (w_trap_cause == c_CAUSE_W'(g)) &&
                             (r_stat_cnt[g] != {CNT_WIDTH{1'b1}})) begin
                    r_stat_cnt[g] <= r_stat_cnt[g] + 1'b1;
                end
            end
        end
    endgenerate

    // Out-of-range selects read as zero
    always_comb begin
        stat_cnt_o = '0;
        if (32'(stat_sel_i) < 32'(EXC_WIDTH)) begin
            stat_cnt_o = r_stat_cnt[stat_sel_i];
        end
    end
`endif

endmodule : trap_monitor
`default_nettype wire

// File: tb/tb_trap_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : tb_trap_monitor
//  Purpose : Self-checking bench for trap_monitor. It runs directed scenarios
//            and then a randomized run, and compares the DUT against a
//            behavioural model. The DUT uses a 4-bit trap counter so that
//            saturation can be reached.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_trap_monitor;

    localparam int c_EW      = 8;
    localparam int c_PW      = 64;
    localparam int c_CW      = 4;
    localparam int c_CNT_MAX = (1 << c_CW) - 1;

    // Spec-level state codes and masks
    localparam int         c_ST_RST = 0, c_ST_NORMAL = 1, c_ST_HALT = 2, c_ST_STEP = 3, c_ST_ERROR = 4;
    localparam logic [7:0] c_ERR  = 8'b0000_0111;
    localparam logic [7:0] c_HALT = 8'b0001_1000;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [c_EW-1:0] exc_i = '0;
    logic [c_PW-1:0] commit_pc_i = '0;
    logic            resume_i = 1'b0;
    logic            step_i = 1'b0;
    logic            pc_we_o;
    logic [2:0]      state_o;
    logic            cause_valid_o;
    logic [2:0]      cause_o;
    logic [c_PW-1:0] epc_o;
    logic [c_CW-1:0] trap_cnt_o;
`ifdef TRAP_STATS_EN
    logic [2:0]      stat_sel_i = '0;
    logic [c_CW-1:0] stat_cnt_o;
`endif

    trap_monitor #(
        .EXC_WIDTH (c_EW),
        .PC_WIDTH  (c_PW),
        .CNT_WIDTH (c_CW)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .exc_i         (exc_i),
        .commit_pc_i   (commit_pc_i),
        .resume_i      (resume_i),
        .step_i        (step_i),
        .pc_we_o       (pc_we_o),
        .state_o       (state_o),
        .cause_valid_o (cause_valid_o),
        .cause_o       (cause_o),
        .epc_o         (epc_o),
        .trap_cnt_o    (trap_cnt_o)
`ifdef TRAP_STATS_EN
        ,
        .stat_sel_i    (stat_sel_i),
        .stat_cnt_o    (stat_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_mode;
    bit          m_valid;
    int          m_cause;
    logic [63:0] m_epc;
    int          m_cnt;
    int          m_stat [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode  = c_ST_RST;
        m_valid = 1'b0;
        m_cause = 0;
        m_epc   = '0;
        m_cnt   = 0;
        for (int i = 0; i < 8; i++) m_stat[i] = 0;
    endtask

    task automatic model_trap(input int c, input logic [63:0] pc, input int next_mode);
        m_mode  = next_mode;
        m_valid = 1'b1;
        m_cause = c;
        m_epc   = pc;
        if (m_cnt < c_CNT_MAX) m_cnt++;
        if (m_stat[c] < c_CNT_MAX) m_stat[c]++;
    endtask

    task automatic model_step(input logic [7:0] exc, input logic [63:0] pc, input bit res, input bit stp);
        logic [7:0] err, hlt;
        err = exc & c_ERR;
        hlt = exc & c_HALT;
        case (m_mode)
            c_ST_RST: m_mode = c_ST_NORMAL;
            c_ST_NORMAL, c_ST_STEP: begin
                if (err != 0)                 model_trap(lowest(err), pc, c_ST_ERROR);
                else if (hlt != 0)            model_trap(lowest(hlt), pc, c_ST_HALT);
                else if (m_mode == c_ST_STEP) m_mode = c_ST_HALT;
            end
            c_ST_HALT: begin
                if (err != 0)  model_trap(lowest(err), pc, c_ST_ERROR);
                else if (res)  m_mode = c_ST_NORMAL;
                else if (stp)  m_mode = c_ST_STEP;
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check("state", 64'(state_o), 64'(m_mode));
        check("pc_we", 64'(pc_we_o), 64'((m_mode == c_ST_NORMAL) || (m_mode == c_ST_STEP)));
        check("cause_valid", 64'(cause_valid_o), 64'(m_valid));
        check("cause", 64'(cause_o), 64'(m_cause));
        check("epc", epc_o, m_epc);
        check("trap_cnt", 64'(trap_cnt_o), 64'(m_cnt));
`ifdef TRAP_STATS_EN
        check("stat_cnt", 64'(stat_cnt_o), 64'(m_stat[stat_sel_i]));
`endif
    endtask

    task automatic do_cycle(input logic [7:0] exc, input logic [63:0] pc, input bit res, input bit stp);
        exc_i       = exc;
        commit_pc_i = pc;
        resume_i    = res;
        step_i      = stp;
`ifdef TRAP_STATS_EN
        stat_sel_i  = 3'($urandom_range(0, 7));
`endif
        @(posedge clk_i);
        model_step(exc, pc, res, stp);
        #1;
        check_all();
    endtask

    // Assert reset asynchronously between edges, then release on a falling edge
    task automatic do_reset();
        #2;
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Leave RST after one cycle
        do_cycle(8'h00, 64'h0, 0, 0);
        check("t1_state_normal", 64'(state_o), 64'(c_ST_NORMAL));

        // EBREAK halts the monitor
        do_cycle(8'h10, 64'h8000_0010, 0, 0);
        check("t2_cause", 64'(cause_o), 64'd4);
        check("t2_epc", epc_o, 64'h8000_0010);
        check("t2_cnt", 64'(trap_cnt_o), 64'd1);

        // Single step produces exactly one write-enable cycle
        do_cycle(8'h00, 64'h0, 0, 1);
        do_cycle(8'h00, 64'h0, 0, 0);
        check("t3_back_halt", 64'(state_o), 64'(c_ST_HALT));
        do_cycle(8'h00, 64'h0, 1, 1);
        check("t3_resume_wins", 64'(state_o), 64'(c_ST_NORMAL));

        // A fatal bit overrides a halting bit and is sticky
        do_cycle(8'h1A, 64'h8000_0020, 0, 0);
        check("t4_cause", 64'(cause_o), 64'd1);
        for (int i = 0; i < 3; i++) do_cycle(8'h00, 64'h0, 1, 1);
        check("t4_sticky", 64'(state_o), 64'(c_ST_ERROR));

        // A fatal bit in HALT wins over resume
        do_reset();
        do_cycle(8'h00, 64'h0, 0, 0);
        do_cycle(8'h08, 64'h100, 0, 0);
        do_cycle(8'h04, 64'h200, 1, 0);
        check("t5_cause", 64'(cause_o), 64'd2);

        // Reset while in HALT clears the latched state
        do_reset();
        do_cycle(8'h00, 64'h0, 0, 0);
        do_cycle(8'h10, 64'h300, 0, 0);
        do_reset();
        check("t5_valid_clr", 64'(cause_valid_o), 64'd0);

        // Three EBREAKs and one ECALL
        do_cycle(8'h00, 64'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(8'h10, 64'(1000 + i), 0, 0);
            do_cycle(8'h00, 64'h0, 1, 0);
        end
        do_cycle(8'h08, 64'h2000, 0, 0);
        do_cycle(8'h00, 64'h0, 1, 0);
`ifdef TRAP_STATS_EN
        stat_sel_i = 3'd4;
        #1;
        check("t6_stat_ebreak", 64'(stat_cnt_o), 64'd3);
        stat_sel_i = 3'd3;
        #1;
        check("t6_stat_ecall", 64'(stat_cnt_o), 64'd1);
`endif

        // Drive the trap counter into saturation
        for (int i = 0; i < 14; i++) begin
            do_cycle(8'h10, 64'(i), 0, 0);
            do_cycle(8'h00, 64'h0, 1, 0);
        end
        check("t6_saturate", 64'(trap_cnt_o), 64'(c_CNT_MAX));

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  exc;
            logic [63:0] pc;
            exc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            pc  = {$urandom, $urandom};
            if ($urandom_range(0, 59) == 0) do_reset();
            do_cycle(exc, pc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_trap_monitor
`default_nettype wire
